mem_port_arbiter: RTL and testbench

Shares the single AXI4 memory master port between the instruction-fetch requester (port I, read-only) and the data-cache requester (port D, read/write). It sequences one single-beat transaction at a time: arbitrate, issue AR or AW+W, collect R or B, return data and status to the winner. It sits between the ICache/DCache controllers and the external AXI interconnect.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and AXI constants for the I/D memory port arbiter.
// Single-beat, 32-bit, non-bursting master only.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR_DATA,
    ST_WR_RESP,
    ST_DONE
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [3:0] AWCACHE     = 4'd11;
  localparam logic [3:0] ARCACHE     = 4'd7;
  localparam logic [2:0] SIZE_4B     = 3'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [7:0] LEN_SINGLE  = 8'd0;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one AXI4 master between the I-fetch and D-cache requesters.
// One single-beat transaction in flight; round-robin on simultaneous requests.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,

  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [3:0]        awcache,

  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,

  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,

  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [3:0]        arcache,

  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  state_t            r_state, w_state;
  logic              r_last, w_last;
  logic              r_port, w_port;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [3:0]        r_wstrb, w_wstrb;
  logic              r_arvalid, w_arvalid;
  logic              r_rready, w_rready;
  logic              r_awvalid, w_awvalid;
  logic              r_wvalid, w_wvalid;
  logic              r_wlast, w_wlast;
  logic              r_bready, w_bready;
  logic              r_i_done, w_i_done;
  logic              r_d_done, w_d_done;
  logic [DATA_W-1:0] r_i_rdata, w_i_rdata;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata;
  logic              r_i_err, w_i_err;
  logic              r_d_err, w_d_err;

  logic w_grant_d;
  logic w_rerr;
  logic w_berr;
  logic w_aw_ok;
  logic w_w_ok;
  logic w_unused;

  assign w_unused = rlast;

  // D wins when alone, or on a tie when I was served last.
  assign w_grant_d = d_req & (~i_req | (r_last == PORT_I));
  assign w_rerr    = (rresp != RESP_OKAY);
  assign w_berr    = (bresp != RESP_OKAY);
  assign w_aw_ok   = ~r_awvalid | awready;
  assign w_w_ok    = ~r_wvalid | wready;

  always_comb begin
    w_state   = r_state;
    w_last    = r_last;
    w_port    = r_port;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_wstrb   = r_wstrb;
    w_arvalid = r_arvalid;
    w_rready  = r_rready;
    w_awvalid = r_awvalid;
    w_wvalid  = r_wvalid;
    w_wlast   = r_wlast;
    w_bready  = r_bready;
    w_i_done  = 1'b0;
    w_d_done  = 1'b0;
    w_i_rdata = r_i_rdata;
    w_d_rdata = r_d_rdata;
    w_i_err   = r_i_err;
    w_d_err   = r_d_err;
    unique case (r_state)
      ST_IDLE: begin
        if (i_req | d_req) begin
          w_port = w_grant_d;
          w_last = w_grant_d;
          w_addr = w_grant_d ? d_addr : i_addr;
          if (w_grant_d & d_we) begin
            w_wdata   = d_wdata;
            w_wstrb   = d_wstrb;
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
            w_wlast   = 1'b1;
            w_state   = ST_WR_ADDR_DATA;
          end else begin
            w_arvalid = 1'b1;
            w_state   = ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: begin
        if (arready) begin
          w_arvalid = 1'b0;
          w_rready  = 1'b1;
          w_state   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (rvalid) begin
          w_rready = 1'b0;
          w_state  = ST_DONE;
          if (r_port == PORT_D) begin
            w_d_rdata = rdata;
            w_d_err   = w_rerr;
            w_d_done  = 1'b1;
          end else begin
            w_i_rdata = rdata;
            w_i_err   = w_rerr;
            w_i_done  = 1'b1;
          end
        end
      end
      ST_WR_ADDR_DATA: begin
        if (r_awvalid & awready) w_awvalid = 1'b0;
        if (r_wvalid & wready) begin
          w_wvalid = 1'b0;
          w_wlast  = 1'b0;
        end
        if (w_aw_ok & w_w_ok) begin
          w_bready = 1'b1;
          w_state  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          w_bready = 1'b0;
          w_d_err  = w_berr;
          w_d_done = 1'b1;
          w_state  = ST_DONE;
        end
      end
      ST_DONE: w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= PORT_D;
      r_port    <= PORT_I;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_err   <= 1'b0;
      r_d_err   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_last    <= w_last;
      r_port    <= w_port;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_wstrb   <= w_wstrb;
      r_arvalid <= w_arvalid;
      r_rready  <= w_rready;
      r_awvalid <= w_awvalid;
      r_wvalid  <= w_wvalid;
      r_wlast   <= w_wlast;
      r_bready  <= w_bready;
      r_i_done  <= w_i_done;
      r_d_done  <= w_d_done;
      r_i_rdata <= w_i_rdata;
      r_d_rdata <= w_d_rdata;
      r_i_err   <= w_i_err;
      r_d_err   <= w_d_err;
    end
  end

  assign i_done  = r_i_done;
  assign i_rdata = r_i_rdata;
  assign i_err   = r_i_err;
  assign d_done  = r_d_done;
  assign d_rdata = r_d_rdata;
  assign d_err   = r_d_err;

  assign awaddr  = r_addr;
  assign awvalid = r_awvalid;
  assign awlen   = LEN_SINGLE;
  assign awsize  = SIZE_4B;
  assign awburst = BURST_FIXED;
  assign awcache = AWCACHE;

  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = r_wlast;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;

  assign araddr  = r_addr;
  assign arvalid = r_arvalid;
  assign arlen   = LEN_SINGLE;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_FIXED;
  assign arcache = ARCACHE;
  assign rready  = r_rready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a configurable AXI slave.
// Expected completions are queued at request time and popped on done.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_done(d_done),
    .d_rdata(d_rdata), .d_err(d_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awcache(awcache),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache),
    .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  localparam bit P_I = 1'b0;
  localparam bit P_D = 1'b1;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_idone = 0;
  int          n_ddone = 0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
  endfunction

  // Slave knobs and bookkeeping
  int          aw_dly = 0, w_dly = 0, r_dly = 0;
  logic [1:0]  slv_rresp = 2'b00, slv_bresp = 2'b00;
  bit          p_ar, p_r, p_aw, p_w, p_b;
  logic [31:0] p_ar_addr, p_aw_addr, p_w_data;
  logic [3:0]  p_w_strb;
  bit          rd_pend, aw_got, w_got, b_pend;
  logic [31:0] rd_addr, aw_a, w_d;
  logic [3:0]  w_s;
  int          rd_wait, aw_cnt, w_cnt;
  int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_viol = 0;
  bit          pv_aw, pv_w;
  logic [31:0] pv_awaddr, pv_wdata;
  logic [3:0]  pv_wstrb;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_ar = 0; p_r = 0; p_aw = 0; p_w = 0; p_b = 0;
      rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
      pv_aw = 0; pv_w = 0; aw_cnt = 0; w_cnt = 0; rd_wait = 0;
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    end else begin
      if (pv_aw && (!awvalid || awaddr !== pv_awaddr)) n_viol++;
      if (pv_w && (!wvalid || wdata !== pv_wdata ||
                   wstrb !== pv_wstrb)) n_viol++;
      if (p_r) rd_pend = 0;
      if (p_ar) begin
        rd_pend = 1; rd_addr = p_ar_addr; rd_wait = 0;
      end
      if (p_aw) begin aw_got = 1; aw_a = p_aw_addr; end
      if (p_w) begin w_got = 1; w_d = p_w_data; w_s = p_w_strb; end
      if (p_b) b_pend = 0;
      if (aw_got && w_got) begin
        slv_mem[aw_a] = merge(slv_rd(aw_a), w_d, w_s);
        aw_got = 0; w_got = 0; b_pend = 1;
      end
      arready = arvalid;
      rvalid = rd_pend && (rd_wait >= r_dly);
      if (rd_pend && !rvalid) rd_wait++;
      rdata = rvalid ? slv_rd(rd_addr) : 32'h0;
      rresp = slv_rresp;
      rlast = 1'b1;
      awready = awvalid && (aw_cnt >= aw_dly);
      if (awvalid && !awready) aw_cnt++; else aw_cnt = 0;
      wready = wvalid && (w_cnt >= w_dly);
      if (wvalid && !wready) w_cnt++; else w_cnt = 0;
      bvalid = b_pend;
      bresp = slv_bresp;
      p_ar = arvalid && arready; p_ar_addr = araddr;
      p_r = rvalid && rready;
      p_aw = awvalid && awready; p_aw_addr = awaddr;
      p_w = wvalid && wready; p_w_data = wdata; p_w_strb = wstrb;
      p_b = bvalid && bready;
      if (p_ar) n_ar++;
      if (p_aw) n_aw++;
      if (p_w) begin n_w++; if (!wlast) n_viol++; end
      if (p_b) n_b++;
      pv_aw = awvalid && !awready; pv_awaddr = awaddr;
      pv_w = wvalid && !wready; pv_wdata = wdata; pv_wstrb = wstrb;
    end
  end

  task automatic pop_chk(input bit port, input logic [31:0] rd,
                         input logic er);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_done", {31'd0, port}, 32'hFFFF_FFFF);
    end else begin
      e = q.pop_front();
      chk("done_port", {31'd0, port}, {31'd0, e.port});
      chk("done_rdata", rd, e.rdata);
      chk("done_err", {31'd0, er}, {31'd0, e.err});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (i_done) begin n_idone++; pop_chk(P_I, i_rdata, i_err); end
      if (d_done) begin n_ddone++; pop_chk(P_D, d_rdata, d_err); end
    end
  end

  task automatic exp_push(input bit port, input bit we,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input bit err);
    exp_t e;
    e.port = port;
    e.err = err;
    if (we) begin
      ref_mem[a] = merge(ref_rd(a), wd, st);
      e.rdata = last_d;
    end else begin
      e.rdata = ref_rd(a);
      if (port) last_d = e.rdata; else last_i = e.rdata;
    end
    q.push_back(e);
  endtask

  task automatic txn(input bit port, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] st);
    bit got;
    @(negedge clk);
    if (port == P_I) begin
      i_req = 1; i_addr = a;
    end else begin
      d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = st;
    end
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = (port == P_I) ? i_done : d_done;
    end
    if (!got) chk("txn_timeout", 32'd0, 32'd1);
    if (port == P_I) i_req = 0; else d_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {26'd0, arvalid, awvalid, wvalid, wlast, rready, bready},
        32'd0);
    chk({tag, "_done"}, {28'd0, i_done, d_done, i_err, d_err}, 32'd0);
  endtask

  int s_aw, s_w, s_b, s_i, s_d;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle(3);
    chk_quiet("reset_ctrl");
    chk("reset_wstrb", {28'd0, wstrb}, 32'd0);
    chk("reset_i_rdata", i_rdata, 32'd0);
    chk("reset_d_rdata", d_rdata, 32'd0);
    chk("const_len", {16'd0, awlen, arlen}, 32'd0);
    chk("const_misc", {14'd0, awsize, arsize, awburst, arburst,
                       awcache, arcache},
        {14'd0, 3'd2, 3'd2, 2'b00, 2'b00, 4'd11, 4'd7});
    rst_n = 1;

    // Tie from reset: I first, then alternation.
    exp_push(P_I, 0, 32'h300, 0, 0, 0);
    exp_push(P_D, 0, 32'h400, 0, 0, 0);
    exp_push(P_I, 0, 32'h304, 0, 0, 0);
    exp_push(P_D, 0, 32'h404, 0, 0, 0);
    fork
      begin
        txn(P_I, 0, 32'h300, 0, 0);
        txn(P_I, 0, 32'h304, 0, 0);
      end
      begin
        txn(P_D, 0, 32'h400, 0, 0);
        txn(P_D, 0, 32'h404, 0, 0);
      end
    join
    idle(2);
    chk("tie_i_dones", n_idone, 2);
    chk("tie_d_dones", n_ddone, 2);

    // Zero-wait I read, cycle accurate.
    exp_push(P_I, 0, 32'h100, 0, 0, 0);
    @(negedge clk);
    i_req = 1; i_addr = 32'h100;
    @(negedge clk);
    chk("rd_c1_arvalid", {31'd0, arvalid}, 32'd1);
    chk("rd_c1_araddr", araddr, 32'h100);
    @(negedge clk);
    chk("rd_c2_rready", {30'd0, arvalid, rready}, 32'd1);
    @(negedge clk);
    chk("rd_c3_i_done", {30'd0, i_done, rready}, 32'd2);
    i_req = 0;
    @(negedge clk);
    chk("rd_c4_i_done", {31'd0, i_done}, 32'd0);

    // Write, awready two cycles ahead of wready.
    s_aw = n_aw; s_w = n_w; s_b = n_b; s_d = n_ddone;
    aw_dly = 0; w_dly = 2;
    exp_push(P_D, 1, 32'h200, 32'h1234_5678, 4'hF, 0);
    txn(P_D, 1, 32'h200, 32'h1234_5678, 4'hF);
    idle(2);
    chk("wr1_aw", n_aw - s_aw, 1);
    chk("wr1_w", n_w - s_w, 1);
    chk("wr1_b", n_b - s_b, 1);
    chk("wr1_dones", n_ddone - s_d, 1);

    // Write, wready two cycles ahead of awready, partial strobe.
    aw_dly = 2; w_dly = 0;
    exp_push(P_D, 1, 32'h204, 32'hCAFE_F00D, 4'b0101, 0);
    txn(P_D, 1, 32'h204, 32'hCAFE_F00D, 4'b0101);
    aw_dly = 0;

    // Simultaneous ready, cycle accurate.
    exp_push(P_D, 1, 32'h208, 32'h0BAD_CAFE, 4'hF, 0);
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h208;
    d_wdata = 32'h0BAD_CAFE; d_wstrb = 4'hF;
    @(negedge clk);
    chk("wr3_c1_valids", {29'd0, awvalid, wvalid, wlast}, 32'd7);
    chk("wr3_c1_awaddr", awaddr, 32'h208);
    chk("wr3_c1_wdata", wdata, 32'h0BAD_CAFE);
    chk("wr3_c1_wstrb", {28'd0, wstrb}, 32'hF);
    @(negedge clk);
    chk("wr3_c2_bready", {29'd0, awvalid, wvalid, bready}, 32'd1);
    @(negedge clk);
    chk("wr3_c3_d_done", {31'd0, d_done}, 32'd1);
    d_req = 0;

    // Read back written data.
    exp_push(P_D, 0, 32'h200, 0, 0, 0);
    txn(P_D, 0, 32'h200, 0, 0);
    exp_push(P_D, 0, 32'h204, 0, 0, 0);
    txn(P_D, 0, 32'h204, 0, 0);
    exp_push(P_I, 0, 32'h208, 0, 0, 0);
    txn(P_I, 0, 32'h208, 0, 0);

    // Error responses on D, I side untouched.
    idle(1);
    s_i = n_idone;
    slv_rresp = 2'b10;
    exp_push(P_D, 0, 32'h40C, 0, 0, 1);
    txn(P_D, 0, 32'h40C, 0, 0);
    slv_rresp = 2'b00;
    slv_bresp = 2'b11;
    exp_push(P_D, 1, 32'h410, 32'h5555_AAAA, 4'hF, 1);
    txn(P_D, 1, 32'h410, 32'h5555_AAAA, 4'hF);
    slv_bresp = 2'b00;
    idle(2);
    chk("err_i_dones", n_idone - s_i, 0);
    chk("err_i_rdata", i_rdata, last_i);
    chk("err_i_err", {31'd0, i_err}, 32'd0);

    // Reset during RD_DATA.
    r_dly = 4;
    s_i = n_idone; s_d = n_ddone;
    @(negedge clk);
    i_req = 1; i_addr = 32'h500;
    @(negedge clk);
    chk("rst_c1_arvalid", {31'd0, arvalid}, 32'd1);
    @(negedge clk);
    chk("rst_c2_rready", {31'd0, rready}, 32'd1);
    rst_n = 0; i_req = 0;
    @(negedge clk);
    chk_quiet("rst_mid");
    chk("rst_mid_rdata", i_rdata | d_rdata, 32'd0);
    last_i = '0; last_d = '0;
    rst_n = 1;
    r_dly = 0;
    idle(6);
    chk("rst_no_done", (n_idone - s_i) + (n_ddone - s_d), 0);
    chk("rst_q_empty", q.size(), 0);
    exp_push(P_I, 0, 32'h104, 0, 0, 0);
    @(negedge clk);
    i_req = 1; i_addr = 32'h104;
    @(negedge clk);
    chk("post_rst_arvalid", {31'd0, arvalid}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_done", {31'd0, i_done}, 32'd1);
    i_req = 0;
    idle(3);

    chk("q_drained", q.size(), 0);
    chk("axi_violations", n_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
